// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: funct codes, FSM state encoding and op classification.
package mdu_ctrl_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [5:0] funct);
    return funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                         FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Core-to-MDU bundle: decoded op and operands in, busy/done and HI/LO out.
interface mdu_ctrl_if #(parameter int DATA_W = 32);

  logic              op_valid_i;
  logic [5:0]        funct_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output op_valid_i, funct_i, rs_data_i, rt_data_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  op_valid_i, funct_i, rs_data_i, rt_data_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_iter_dp.sv
// Iterative mul/div datapath: one shift-add or restoring-divide step per step_i cycle.
// No backpressure; load_i wins over step_i and seeds acc=0, sh=operand A, divisor/multiplicand=B.
module mdu_iter_dp #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] sh_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] diff;
  logic              ge;

  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    b_d    = b_q;
    sum    = {1'b0, acc_q} + {1'b0, {DATA_W{sh_q[0]}} & b_q};
    rem_sh = {acc_q, sh_q[DATA_W-1]};
    ge     = rem_sh >= {1'b0, b_q};
    // Partial remainder stays below the divisor, so the low DATA_W bits suffice.
    diff   = rem_sh[DATA_W-1:0] - b_q;
    if (load_i) begin
      acc_d = '0;
      sh_d  = a_i;
      b_d   = b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        acc_d = ge ? diff : rem_sh[DATA_W-1:0];
        sh_d  = {sh_q[DATA_W-2:0], ge};
      end else begin
        acc_d = sum[DATA_W:1];
        sh_d  = {sum[0], sh_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
    end
  end

  assign acc_o = acc_q;
  assign sh_o  = sh_q;

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO owner and MULT/MULTU/DIV/DIVU sequencer; MTHI/MTLO commit at accept, mul/div busy DATA_W+1 cycles.
// Ops seen while busy are dropped (no queue). MDU_EARLY_OUT_EN skips CALC for zero operand / zero divisor.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  mdu_ctrl_if.slave mdu
);

  localparam int CNT_W = $clog2(DATA_W);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d, zero_q, zero_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, rs_raw_q, rs_raw_d;

  logic              busy, accept, op_mul, op_div, op_signed, rs_neg, rt_neg, early;
  logic              dp_load, dp_step;
  logic [DATA_W-1:0] rs_mag, rt_mag, dp_acc, dp_sh, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] prod, prod_fix;

  assign busy      = state_q inside {S_CALC, S_SIGN};
  assign accept    = mdu.op_valid_i && !busy && is_mdu_op(mdu.funct_i);
  assign op_mul    = mdu.funct_i inside {FUNCT_MULT, FUNCT_MULTU};
  assign op_div    = mdu.funct_i inside {FUNCT_DIV, FUNCT_DIVU};
  assign op_signed = mdu.funct_i inside {FUNCT_MULT, FUNCT_DIV};
  assign rs_neg    = op_signed && mdu.rs_data_i[DATA_W-1];
  assign rt_neg    = op_signed && mdu.rt_data_i[DATA_W-1];
  assign rs_mag    = rs_neg ? -mdu.rs_data_i : mdu.rs_data_i;
  assign rt_mag    = rt_neg ? -mdu.rt_data_i : mdu.rt_data_i;

`ifdef MDU_EARLY_OUT_EN
  assign early = (op_mul && (mdu.rs_data_i == '0 || mdu.rt_data_i == '0)) ||
                 (op_div && mdu.rt_data_i == '0);
`else
  assign early = 1'b0;
`endif

  // Early-out multiplies never run CALC, so a zero operand forces the product here.
  assign prod     = zero_q ? '0 : {dp_acc, dp_sh};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -dp_sh : dp_sh;
  assign rem_fix  = rem_neg_q ? -dp_acc : dp_acc;

  mdu_iter_dp #(.DATA_W(DATA_W)) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .is_div_i (div_q),
    .a_i      (rs_mag),
    .b_i      (rt_mag),
    .acc_o    (dp_acc),
    .sh_o     (dp_sh)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rs_raw_d  = rs_raw_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    case (state_q)
      S_CALC: begin
        dp_step = 1'b1;
        if (cnt_q == '0) state_d = S_SIGN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SIGN: begin
        state_d = S_DONE;
        if (div_q) begin
          if (dz_q) begin
            hi_d = rs_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives.
        state_d = S_IDLE;
        if (accept) begin
          if (mdu.funct_i == FUNCT_MTHI) hi_d = mdu.rs_data_i;
          if (mdu.funct_i == FUNCT_MTLO) lo_d = mdu.rs_data_i;
          if (op_mul || op_div) begin
            dp_load   = 1'b1;
            cnt_d     = CNT_W'(DATA_W - 1);
            div_d     = op_div;
            neg_d     = rs_neg ^ rt_neg;
            rem_neg_d = rs_neg;
            dz_d      = op_div && (mdu.rt_data_i == '0);
            zero_d    = op_mul && (mdu.rs_data_i == '0 || mdu.rt_data_i == '0);
            rs_raw_d  = mdu.rs_data_i;
            state_d   = early ? S_SIGN : S_CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      rs_raw_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rs_raw_q  <= rs_raw_d;
    end
  end

  assign mdu.busy_o = busy;
  assign mdu.done_o = (state_q == S_DONE);
  assign mdu.hi_o   = hi_q;
  assign mdu.lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed corner cases plus random ops; results are predicted with plain
// integer arithmetic and checked by a done-driven monitor popping an expectation queue.
module tb_mdu_ctrl;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mdu_ctrl_if #(.DATA_W(32)) mif ();

  mdu_ctrl #(.DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mdu   (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic bit is_early(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if ((f == F_MULT || f == F_MULTU) && (a == 32'd0 || b == 32'd0)) return 1'b1;
    if ((f == F_DIV || f == F_DIVU) && b == 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint          sp;
    longint unsigned up;
    int              ia, ib;
    ia = a;
    ib = b;
    h  = 32'd0;
    l  = 32'd0;
    if (f == F_MULT) begin
      sp = longint'(ia) * longint'(ib);
      {h, l} = 64'(sp);
    end else if (f == F_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      {h, l} = up;
    end else if (b == 32'd0) begin
      l = 32'hFFFF_FFFF;
      h = a;
    end else if (f == F_DIVU) begin
      l = a / b;
      h = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000;
      h = 32'd0;
    end else begin
      l = 32'(ia / ib);
      h = 32'(ia % ib);
    end
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    case ($urandom_range(0, 9))
      0:       return F_MULT;
      1:       return F_MULTU;
      2:       return F_DIV;
      3:       return F_DIVU;
      4:       return F_MTHI;
      5:       return F_MTLO;
      6:       return F_MFHI;
      7:       return F_MFLO;
      8:       return 6'($urandom_range(20, 23));
      default: return 6'($urandom_range(28, 63));
    endcase
  endfunction

  // Called at a falling edge with the DUT able to accept; returns at a falling edge.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit junk);
    exp_t        e;
    logic [31:0] eh, el;
    int          lat, bcnt;
    mif.op_valid_i = 1'b1;
    mif.funct_i    = f;
    mif.rs_data_i  = a;
    mif.rt_data_i  = b;
    @(negedge clk);
    mif.op_valid_i = 1'b0;
    if (is_muldiv(f)) begin
      ref_model(f, a, b, eh, el);
      lat   = (EARLY_EN && is_early(f, a, b)) ? 1 : 33;
      e.hi  = eh;
      e.lo  = el;
      e.cyc = cyc + lat;
      exp_q.push_back(e);
      model_hi = eh;
      model_lo = el;
      bcnt = 0;
      while (mif.busy_o === 1'b1 && bcnt < 100) begin
        bcnt++;
        if (junk) begin
          mif.op_valid_i = 1'b1;
          mif.funct_i    = ($urandom_range(0, 1) == 0) ? F_MULTU : F_MTHI;
          mif.rs_data_i  = $urandom;
          mif.rt_data_i  = $urandom;
        end
        @(negedge clk);
      end
      mif.op_valid_i = 1'b0;
      chk("busy_cycles", 64'(bcnt), 64'(lat));
    end else begin
      if (f == F_MTHI) model_hi = a;
      if (f == F_MTLO) model_lo = a;
      chk("single_busy", 64'(mif.busy_o), 64'd0);
      chk("single_done", 64'(mif.done_o), 64'd0);
      chk("single_hi", 64'(mif.hi_o), 64'(model_hi));
      chk("single_lo", 64'(mif.lo_o), 64'(model_lo));
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && mif.done_o === 1'b1) begin
      chk("done_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result_hi", 64'(mif.hi_o), 64'(e.hi));
        chk("result_lo", 64'(mif.lo_o), 64'(e.lo));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: no completion by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    mif.op_valid_i = 1'b0;
    mif.funct_i    = 6'd0;
    mif.rs_data_i  = 32'd0;
    mif.rt_data_i  = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(mif.busy_o), 64'd0);
    chk("reset_done", 64'(mif.done_o), 64'd0);
    chk("reset_hi", 64'(mif.hi_o), 64'd0);
    chk("reset_lo", 64'(mif.lo_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(F_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
    run_op(F_DIVU,  32'd100,       32'd0,         1'b0);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(F_DIV,   32'hFFFF_FF9C, 32'd0,         1'b0);
    run_op(F_MULT,  32'd0,         32'hFFFF_FFF0, 1'b0);
    run_op(F_MTHI,  32'h1234_5678, 32'd0,         1'b0);
    run_op(F_MTLO,  32'h9ABC_DEF0, 32'd0,         1'b0);
    run_op(F_MFHI,  32'h5555_5555, 32'd1,         1'b0);
    run_op(6'h2A,   32'hAAAA_AAAA, 32'd3,         1'b0);
    run_op(F_DIV,   32'd1000,      32'hFFFF_FFF9, 1'b1);
    run_op(F_MULTU, 32'd65537,     32'd65535,     1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(rand_funct(), rand_opnd(), rand_opnd(), ($urandom_range(0, 3) == 0));
    end

    run_op(F_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op(F_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    mif.op_valid_i = 1'b1;
    mif.funct_i    = F_MULTU;
    mif.rs_data_i  = 32'h0001_0003;
    mif.rt_data_i  = 32'h0000_0101;
    @(negedge clk);
    mif.op_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_busy", 64'(mif.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    chk("abort_busy", 64'(mif.busy_o), 64'd0);
    chk("abort_done", 64'(mif.done_o), 64'd0);
    chk("abort_hi", 64'(mif.hi_o), 64'd0);
    chk("abort_lo", 64'(mif.lo_o), 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_commit_hi", 64'(mif.hi_o), 64'd0);
    chk("abort_no_commit_lo", 64'(mif.lo_o), 64'd0);

    run_op(F_DIVU, 32'd12345, 32'd10, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
